// File: rtl/zero_heap_pkg.sv
// Shared types for the heap array allocator: FSM states, operation kinds and results.
package zero_heap_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef enum logic {OP_ALLOC, OP_FREE} op_t;

    typedef enum logic [1:0] {RES_OK, RES_EXHAUSTED, RES_BADFREE} res_t;

    // Index width for a vector of n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/heap_array_allocator_if.sv
// Requester-side bundle of the heap array allocator, plus the FSM state for observation.
// Handshake: allocReq/freeReq are one-cycle pulses; each accepted pulse is answered by exactly one ack pulse.
interface heap_array_allocator_if
    import zero_heap_pkg::*;
#(
    parameter int NReq = 2,
    parameter int AW   = 4
);
    logic [NReq-1:0]    allocReq;
    logic [NReq-1:0]    freeReq;
    logic [NReq*AW-1:0] freeArray;
    logic [NReq-1:0]    ack;
    logic [AW-1:0]      allocArray;
    logic               errExhausted;
    logic               errBadFree;
    logic               sizeClear;
    logic [AW-1:0]      sizeClearArray;
    logic [AW:0]        inUse;
    logic [AW:0]        highWater;
    state_t             dbg_state;

    modport master (
        output allocReq, freeReq, freeArray,
        input  ack, allocArray, errExhausted, errBadFree,
        input  sizeClear, sizeClearArray, inUse, highWater, dbg_state
    );

    modport slave (
        input  allocReq, freeReq, freeArray,
        output ack, allocArray, errExhausted, errBadFree,
        output sizeClear, sizeClearArray, inUse, highWater, dbg_state
    );

endinterface

// File: rtl/heap_array_allocator_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import zero_heap_pkg::*;
#(
    parameter int NReq = 2,
    localparam int GW  = idx_width(NReq)
) (
    input  logic [NReq-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   grant,
    output logic            valid
);

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < NReq; i++) begin
            idx = (int'(ptr) + i) % NReq;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/heap_array_allocator.sv
// Shared heap array-number allocator: round-robin arbitration, LIFO reuse of freed arrays,
// fresh numbers from a saturating counter, and a size-clear pulse on every successful alloc.
module heap_array_allocator
    import zero_heap_pkg::*;
#(
    parameter int NArrays = 16,
    parameter int NReq    = 2,
    parameter int AW      = $clog2(NArrays)
) (
    input logic                   clock,
    input logic                   reset,
    heap_array_allocator_if.slave bus
);

    localparam int GW = idx_width(NReq);

    state_t            state, state_next;
    op_t               op;
    res_t              res;
    logic [GW-1:0]     grant, rr_ptr, arb_grant;
    logic              arb_valid;
    logic [NReq-1:0]   alloc_pend, free_pend, grant_mask, alloc_clr, free_clr;
    logic [AW-1:0]     free_reg [NReq];
    logic [AW-1:0]     stack [NArrays];
    logic [AW:0]       stack_top, allocs, in_use_cnt, high_water;
    logic [NArrays-1:0] in_use_map;
    logic [AW-1:0]     alloc_hold, free_arr, pop_arr, exec_arr;
    res_t              exec_res;

    rr_arbiter #(.NReq(NReq)) u_arb (
        .req   (alloc_pend | free_pend),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (arb_valid) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ack            = '0;
        bus.errExhausted   = 1'b0;
        bus.errBadFree     = 1'b0;
        bus.sizeClear      = 1'b0;
        bus.sizeClearArray = '0;
        if (state == DONE) begin
            bus.ack          = grant_mask;
            bus.errExhausted = (res == RES_EXHAUSTED);
            bus.errBadFree   = (res == RES_BADFREE);
            if (op == OP_ALLOC && res == RES_OK) begin
                bus.sizeClear      = 1'b1;
                bus.sizeClearArray = alloc_hold;
            end
        end
    end

    assign bus.allocArray = alloc_hold;
    assign bus.inUse      = in_use_cnt;
    assign bus.highWater  = high_water;
    assign bus.dbg_state  = state;

    // Served pending bit drops in DONE; a fresh pulse in that same cycle re-arms it.
    assign grant_mask = NReq'(1) << grant;
    assign alloc_clr  = (state == DONE && op == OP_ALLOC) ? grant_mask : '0;
    assign free_clr   = (state == DONE && op == OP_FREE)  ? grant_mask : '0;

    assign free_arr = free_reg[grant];
    assign pop_arr  = stack[AW'(stack_top - 1'b1)];

    always_comb begin
        exec_res = RES_OK;
        exec_arr = free_arr;
        if (op == OP_ALLOC) begin
            if (stack_top != '0) begin
                exec_arr = pop_arr;
            end else if (allocs < (AW+1)'(NArrays)) begin
                exec_arr = allocs[AW-1:0];
            end else begin
                exec_res = RES_EXHAUSTED;
                exec_arr = '0;
            end
        end else if (!in_use_map[free_arr]) begin
            exec_res = RES_BADFREE;
        end
    end

    // Payload storage carries no reset: contents only matter under a valid pending bit or stack depth.
    always_ff @(posedge clock) begin
        for (int r = 0; r < NReq; r++) begin
            if (bus.freeReq[r]) free_reg[r] <= bus.freeArray[r*AW +: AW];
        end
        if (!reset && state == EXEC && op == OP_FREE && exec_res == RES_OK)
            stack[AW'(stack_top)] <= free_arr;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alloc_pend <= '0;
            free_pend  <= '0;
            grant      <= '0;
            op         <= OP_ALLOC;
            res        <= RES_OK;
            rr_ptr     <= '0;
            alloc_hold <= '0;
            stack_top  <= '0;
            allocs     <= '0;
            in_use_map <= '0;
            in_use_cnt <= '0;
            high_water <= '0;
        end else begin
            alloc_pend <= (alloc_pend & ~alloc_clr) | bus.allocReq;
            free_pend  <= (free_pend & ~free_clr) | bus.freeReq;
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant <= arb_grant;
                        op    <= free_pend[arb_grant] ? OP_FREE : OP_ALLOC;
                    end
                end
                EXEC: begin
                    res <= exec_res;
                    if (op == OP_ALLOC) begin
                        alloc_hold <= exec_arr;
                        if (exec_res == RES_OK) begin
                            in_use_map[exec_arr] <= 1'b1;
                            in_use_cnt           <= in_use_cnt + 1'b1;
                            if (in_use_cnt + 1'b1 > high_water) high_water <= in_use_cnt + 1'b1;
                            if (stack_top != '0) stack_top <= stack_top - 1'b1;
                            else                 allocs    <= allocs + 1'b1;
                        end
                    end else if (exec_res == RES_OK) begin
                        in_use_map[free_arr] <= 1'b0;
                        in_use_cnt           <= in_use_cnt - 1'b1;
                        stack_top            <= stack_top + 1'b1;
                    end
                end
                DONE: begin
                    rr_ptr <= (grant == GW'(NReq - 1)) ? '0 : grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
